// File: rtl/regfile_pkg.sv
// Shared constants and types for the MIPS register bank write path.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready request bundle from NUM_REQ write sources to the arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register bank write port, registered output.
module regfile_write_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = 5,
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 16,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_arbiter_if.slave req_if,
  input  logic                 flush,
  output logic                 rf_we3,
  output logic [ADDR_W-1:0]    rf_a3,
  output logic [DATA_W-1:0]    rf_wd3,
  output logic [IW-1:0]        grant_id,
  output logic [CNT_W-1:0]     conflict_cnt
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win;
  logic               any;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [IW-1:0]      rr_q, rr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_if.req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign xfer     = any && !flush;
  assign sel_addr = req_if.req_addr[win*ADDR_W +: ADDR_W];
  assign sel_data = req_if.req_data[win*DATA_W +: DATA_W];

  always_comb begin
    req_if.req_ready = flush ? '0 : gnt;
  end

  always_comb begin
    rr_d  = rr_q;
    we_d  = 1'b0;
    a_d   = a_q;
    wd_d  = wd_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    if (xfer) begin
      rr_d  = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
      // $zero is accepted but never written
      we_d  = (sel_addr != ADDR_W'(REG_ZERO));
      a_d   = sel_addr;
      wd_d  = sel_data;
      gid_d = win;
    end
    if (!flush && $countones(req_if.req_valid) >= 2 && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      we_q  <= 1'b0;
      a_q   <= '0;
      wd_q  <= '0;
      gid_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      we_q  <= we_d;
      a_q   <= a_d;
      wd_q  <= wd_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
    end
  end

  assign rf_we3       = we_q;
  assign rf_a3        = a_q;
  assign rf_wd3       = wd_q;
  assign grant_id     = gid_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: arbiter plus a behavioural register bank and write scoreboard.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [0:0]  grant_id;
  logic [3:0]  conflict_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  logic [31:0] bank [32];

  regfile_write_arbiter_if #(
    .NUM_REQ(2), .ADDR_W(5), .DATA_W(32)
  ) rif ();

  regfile_write_arbiter #(
    .NUM_REQ(2), .ADDR_W(5), .DATA_W(32), .CNT_W(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (rif),
    .flush        (flush),
    .rf_we3       (rf_we3),
    .rf_a3        (rf_a3),
    .rf_wd3       (rf_wd3),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we3 && rf_a3 != 5'd0) bank[rf_a3] <= rf_wd3;

  // every write on the bank port must match the next expected acceptance
  always @(negedge clk) begin
    if (rst_n && rf_we3) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_spurious a3=%0d wd3=%h", rf_a3, rf_wd3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_a3 !== e.a || rf_wd3 !== e.d) begin
          bad++;
          $display("FAIL sb_order got %0d/%h want %0d/%h",
                   rf_a3, rf_wd3, e.a, e.d);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
    rif.req_valid[i]       = v;
    rif.req_addr[i*5 +: 5]  = a;
    rif.req_data[i*32 +: 32] = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_in();
    rif.req_valid = '0;
    rif.req_addr  = '0;
    rif.req_data  = '0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({rf_we3, rf_a3, rf_wd3, grant_id, conflict_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_vals got %b/%0d/%h/%0d/%0d want all 0",
               rf_we3, rf_a3, rf_wd3, grant_id, conflict_cnt);
    end
    @(negedge clk);
    set_req(0, 1'b1, 5'd9, 32'h1234_5678);
    @(posedge clk);
    #1;
    clear_in();
    total++;
    if (rf_we3 !== 1'b1 || rf_a3 !== 5'd9) begin
      bad++;
      $display("FAIL reset_pre we3=%b a3=%0d want 1/9", rf_we3, rf_a3);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rf_we3, rf_a3, rf_wd3, grant_id} !== '0) begin
      bad++;
      $display("FAIL reset_async got %b/%0d/%h/%0d want 0",
               rf_we3, rf_a3, rf_wd3, grant_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bank[9] !== 32'h0) begin
      bad++;
      $display("FAIL reset_nowrite bank9=%h want 0", bank[9]);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_ready got %b want 01", rif.req_ready);
    end
    push(5'd5, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    total++;
    if (rf_we3 !== 1'b1 || rf_a3 !== 5'd5 ||
        rf_wd3 !== 32'hDEAD_BEEF || grant_id !== 1'b0) begin
      bad++;
      $display("FAIL single_out got %b/%0d/%h/%0d want 1/5/deadbeef/0",
               rf_we3, rf_a3, rf_wd3, grant_id);
    end
    @(negedge clk);
    clear_in();
    @(posedge clk);
    #1;
    total++;
    if (bank[5] !== 32'hDEAD_BEEF || rf_we3 !== 1'b0) begin
      bad++;
      $display("FAIL single_bank reg5=%h we3=%b want deadbeef/0",
               bank[5], rf_we3);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hA0A0_0000);
    set_req(1, 1'b1, 5'd2, 32'hA1A1_0001);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (rif.req_ready !== exp_rdy[c]) begin
        bad++;
        $display("FAIL cont_ready c=%0d got %b want %b",
                 c, rif.req_ready, exp_rdy[c]);
      end
      if (c % 2 == 0) push(5'd1, 32'hA0A0_0000);
      else            push(5'd2, 32'hA1A1_0001);
      @(posedge clk);
      #1;
      total++;
      if (grant_id !== 1'(c % 2)) begin
        bad++;
        $display("FAIL cont_gid c=%0d got %0d want %0d",
                 c, grant_id, c % 2);
      end
      @(negedge clk);
    end
    clear_in();
    #1;
    total++;
    if (conflict_cnt !== 4'd4) begin
      bad++;
      $display("FAIL cont_cnt got %0d want 4", conflict_cnt);
    end
  endtask

  task automatic test_zero();
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h0000_0033);
    push(5'd3, 32'h0000_0033);
    @(negedge clk);
    clear_in();
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    total++;
    if (rif.req_ready !== 2'b10) begin
      bad++;
      $display("FAIL zero_ready got %b want 10", rif.req_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (rf_we3 !== 1'b0 || grant_id !== 1'b1) begin
      bad++;
      $display("FAIL zero_out we3=%b gid=%0d want 0/1", rf_we3, grant_id);
    end
    @(negedge clk);
    set_req(0, 1'b1, 5'd4, 32'h0000_0044);
    set_req(1, 1'b1, 5'd6, 32'h0000_0066);
    #1;
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL zero_ptr got %b want 01", rif.req_ready);
    end
    push(5'd4, 32'h0000_0044);
    @(negedge clk);
    clear_in();
    @(posedge clk);
    #1;
    total++;
    if (bank[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_bank reg0=%h want 0", bank[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    push(5'd7, 32'h0000_0077);
    @(negedge clk);
    set_req(0, 1'b1, 5'd8, 32'h0000_0088);
    set_req(1, 1'b1, 5'd10, 32'h0000_00AA);
    flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (rif.req_ready !== 2'b00) begin
        bad++;
        $display("FAIL flush_ready c=%0d got %b want 00",
                 c, rif.req_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (rf_we3 !== 1'b0 || conflict_cnt !== 4'd0) begin
        bad++;
        $display("FAIL flush_out c=%0d we3=%b cnt=%0d want 0/0",
                 c, rf_we3, conflict_cnt);
      end
      @(negedge clk);
    end
    flush = 1'b0;
    #1;
    total++;
    if (rif.req_ready !== 2'b10) begin
      bad++;
      $display("FAIL flush_ptr got %b want 10", rif.req_ready);
    end
    push(5'd10, 32'h0000_00AA);
    @(posedge clk);
    #1;
    total++;
    if (conflict_cnt !== 4'd1) begin
      bad++;
      $display("FAIL flush_cnt got %0d want 1", conflict_cnt);
    end
    @(negedge clk);
    clear_in();
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 1'b1, 5'd11, 32'h0000_0B0B);
    set_req(1, 1'b1, 5'd12, 32'h0000_0C0C);
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) push(5'd11, 32'h0000_0B0B);
      else            push(5'd12, 32'h0000_0C0C);
      @(posedge clk);
      #1;
      if (c == 14 || c == 19) begin
        total++;
        if (conflict_cnt !== 4'd15) begin
          bad++;
          $display("FAIL sat_cnt c=%0d got %0d want 15",
                   c, conflict_cnt);
        end
      end
      @(negedge clk);
    end
    clear_in();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    clear_in();
    test_reset();
    test_single();
    test_contention();
    test_zero();
    test_flush();
    test_saturation();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
